// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-direction predictor.
//   ctr2_t        : 2-bit saturating direction counter with SN/WN/WT/ST encodings
//   bpred_state_t : table initialisation FSM states
//   CTR_RESET     : counter value written to every entry by the init walk
package bpred_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SN = 2'b00;  // strongly not-taken
  localparam ctr2_t WN = 2'b01;  // weakly not-taken
  localparam ctr2_t WT = 2'b10;  // weakly taken
  localparam ctr2_t ST = 2'b11;  // strongly taken

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpred_state_t;

  localparam ctr2_t CTR_RESET = WN;

endpackage

// File: rtl/bpred_sat_ctr.sv
// Combinational next-state for a 2-bit saturating direction counter.
// Ports:
//   cur   in  : current counter value
//   taken in  : resolved branch outcome (1 = count up, 0 = count down)
//   nxt   out : trained counter value, clamped at SN and ST
module bpred_sat_ctr
  import bpred_pkg::*;
(
  input  ctr2_t cur,
  input  logic  taken,
  output ctr2_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SN) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch-direction predictor: table of 2-bit saturating counters indexed
// by pc[IDX_BITS+1:2], with an optional direct-mapped BTB.
// After every reset an init walk writes one entry per cycle; predictions and
// training are suppressed until the walk finishes (ready = 1).
// Optional feature macro: BRANCH_PREDICTOR_BTB_EN (adds valid/tag/target per entry).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   lookup_pc             : fetch PC, predicted combinationally
//   pred_taken/hit/target : prediction outputs (all 0 while not ready)
//   upd_valid/pc/taken/target : resolved branch for training
//   ready                 : table initialised
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        ready
);

  localparam int unsigned ENTRIES  = 2 ** IDX_BITS;
  localparam int unsigned TAG_BITS = 30 - IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

  bpred_state_t        state_q, state_d;
  logic [IDX_BITS-1:0] init_idx_q, init_idx_d;

  ctr2_t ctr_q [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  ctr2_t               up_ctr_nxt;
  logic                upd_live;

  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  ctr2_t               wr_ctr;

  assign lk_idx   = lookup_pc[IDX_BITS+1:2];
  assign up_idx   = upd_pc[IDX_BITS+1:2];
  assign ready    = (state_q == RUN);
  assign upd_live = ready && upd_valid;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = RUN;
      end
      RUN: ;
    endcase
  end

  // Counter table: one write port shared by the init walk and training
  bpred_sat_ctr u_sat_ctr (
    .cur   (ctr_q[up_idx]),
    .taken (upd_taken),
    .nxt   (up_ctr_nxt)
  );

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = init_idx_q;
    wr_ctr = CTR_RESET;
    if (!rst) begin
      if (state_q == INIT) begin
        wr_en = 1'b1;
      end else if (upd_live) begin
        wr_en  = 1'b1;
        wr_idx = up_idx;
        wr_ctr = up_ctr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ctr_q[wr_idx] <= wr_ctr;
  end

`ifdef BRANCH_PREDICTOR_BTB_EN
  logic                btb_valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [29:0]         btb_target_q [ENTRIES];

  // Only taken outcomes allocate; not-taken training leaves the BTB alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        btb_valid_q[init_idx_q] <= 1'b0;
      end else if (upd_live && upd_taken) begin
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= upd_pc[31:IDX_BITS+2];
        btb_target_q[up_idx] <= upd_target[31:2];
      end
    end
  end

  always_comb begin
    pred_hit    = ready && btb_valid_q[lk_idx] &&
                  (btb_tag_q[lk_idx] == lookup_pc[31:IDX_BITS+2]);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_hit ? {btb_target_q[lk_idx], 2'b00} : 32'd0;
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};
`else
  always_comb begin
    pred_hit    = ready;
    pred_taken  = ready && ctr_q[lk_idx][1];
    pred_target = 32'd0;
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0], upd_pc[31:IDX_BITS+2],
                         upd_pc[1:0], upd_target, TAG_BITS[0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. Works with and without
// BRANCH_PREDICTOR_BTB_EN defined; the reference model tracks the same option.
module tb_branch_predictor;

  localparam int unsigned IDX_BITS = 6;
  localparam int unsigned ENTRIES  = 2 ** IDX_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        ready;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (lookup_pc),
    .pred_taken  (pred_taken),
    .pred_hit    (pred_hit),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // Reference model: counter values as plain integers 0..3, BTB as arrays.
  int          m_ctr   [ENTRIES];
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_ready = 1'b0;
  int          m_walk  = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit exp_hit(logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_BTB_EN
    return m_ready && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> (IDX_BITS + 2)));
`else
    return m_ready;
`endif
  endfunction

  function automatic bit exp_taken(logic [31:0] pc);
    return exp_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_BTB_EN
    return exp_hit(pc) ? m_tgt[idx_of(pc)] : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  // Advance one rising edge and apply the spec's rules to the model.
  task automatic tick();
    int i;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_walk  = 0;
      for (int k = 0; k < ENTRIES; k++) begin
        m_ctr[k]   = 1;
        m_valid[k] = 1'b0;
      end
    end else if (!m_ready) begin
      m_walk++;
      if (m_walk == ENTRIES) m_ready = 1'b1;
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      if (upd_taken) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_valid[i] = 1'b1;
        m_tag[i]   = upd_pc >> (IDX_BITS + 2);
        m_tgt[i]   = upd_target & 32'hFFFF_FFFC;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_valid = 1'b0;
    lookup_pc = 32'h0000_0100;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0 || pred_taken !== 1'b0 || pred_hit !== 1'b0 || pred_target !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got r=%b t=%b h=%b tgt=%h expected all 0",
               ready, pred_taken, pred_hit, pred_target);
    end
    rst = 1'b0;
    for (int k = 1; k <= ENTRIES; k++) begin
      upd_valid  = 1'($urandom);
      upd_pc     = $urandom;
      upd_taken  = 1'($urandom);
      upd_target = $urandom;
      lookup_pc  = $urandom;
      tick();
      checks++;
      if (ready !== (k == ENTRIES)) begin
        errors++;
        $display("FAIL init_ready edge %0d: got %b expected %b", k, ready, k == ENTRIES);
      end
      if (k < ENTRIES) begin
        checks++;
        if (pred_taken !== 1'b0 || pred_hit !== 1'b0 || pred_target !== 32'd0) begin
          errors++;
          $display("FAIL init_outputs edge %0d: got t=%b h=%b tgt=%h expected 0",
                   k, pred_taken, pred_hit, pred_target);
        end
      end
    end
    upd_valid = 1'b0;
    // Every entry must be WN regardless of the updates fired during INIT.
    for (int i = 0; i < ENTRIES; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_taken !== exp_taken(lookup_pc)) begin
        errors++;
        $display("FAIL init_table idx %0d: got %b expected 0", i, pred_taken);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    bit exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    lookup_pc  = 32'h0000_0100;
    upd_pc     = 32'h0000_0100;
    upd_target = 32'h0000_0200;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_start: got %b expected 0", pred_taken);
    end
    upd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      upd_taken = (j < 3);
      tick();
      checks++;
      if (pred_taken !== exp_seq[j] || pred_taken !== exp_taken(lookup_pc)) begin
        errors++;
        $display("FAIL saturation step %0d: got %b expected %b", j, pred_taken, exp_seq[j]);
      end
    end
    upd_valid = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    upd_pc     = 32'h0000_0004;
    upd_target = 32'h0000_0800;
    upd_taken  = 1'b1;
    upd_valid  = 1'b1;
    repeat (2) tick();
    upd_valid = 1'b0;
    lookup_pc = 32'h0000_0104;
    #1;
    checks++;
`ifdef BRANCH_PREDICTOR_BTB_EN
    if (pred_taken !== 1'b0 || pred_hit !== 1'b0 || pred_taken !== exp_taken(lookup_pc)) begin
      errors++;
      $display("FAIL alias_btb: got t=%b h=%b expected 0/0", pred_taken, pred_hit);
    end
`else
    if (pred_taken !== 1'b1 || pred_taken !== exp_taken(lookup_pc)) begin
      errors++;
      $display("FAIL alias: got %b expected 1", pred_taken);
    end
`endif
    tick();
    // Two not-taken updates (ST->WT->WN) with the lookup on the same index.
    lookup_pc = 32'h0000_0004;
    upd_taken = 1'b0;
    upd_valid = 1'b1;
    tick();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_taken !== exp_taken(lookup_pc)) begin
      errors++;
      $display("FAIL same_cycle_old: got %b expected 1", pred_taken);
    end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (pred_taken !== 1'b0 || pred_taken !== exp_taken(lookup_pc)) begin
      errors++;
      $display("FAIL same_cycle_after: got %b expected 0", pred_taken);
    end
    tick();
  endtask

`ifdef BRANCH_PREDICTOR_BTB_EN
  task automatic test_btb();
    upd_pc     = 32'h0000_0020;
    upd_target = 32'h0000_0400;
    upd_taken  = 1'b1;
    upd_valid  = 1'b1;
    tick();
    upd_valid = 1'b0;
    lookup_pc = 32'h0000_0020;
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h0000_0400) begin
      errors++;
      $display("FAIL btb_hit: got h=%b tgt=%h expected 1/00000400", pred_hit, pred_target);
    end
    tick();
    lookup_pc = 32'h0000_1020;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      errors++;
      $display("FAIL btb_tag_miss: got h=%b t=%b tgt=%h expected 0/0/0",
               pred_hit, pred_taken, pred_target);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    lookup_pc  = 32'h0000_0024;
    upd_pc     = 32'h0000_0024;
    upd_valid  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      upd_taken  = 1'($urandom);
      upd_target = $urandom;
      #1;
      checks++;
      if (pred_taken !== exp_taken(lookup_pc) || pred_hit !== exp_hit(lookup_pc)) begin
        errors++;
        $display("FAIL back_to_back step %0d: got t=%b h=%b expected %b/%b",
                 j, pred_taken, pred_hit, exp_taken(lookup_pc), exp_hit(lookup_pc));
      end
      tick();
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      upd_valid  = 1'($urandom);
      upd_pc     = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_taken  = 1'($urandom);
      upd_target = $urandom;
      lookup_pc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      #1;
      checks++;
      if (pred_taken !== exp_taken(lookup_pc) || pred_hit !== exp_hit(lookup_pc) ||
          pred_target !== exp_target(lookup_pc)) begin
        errors++;
        $display("FAIL random pc=%h: got t=%b h=%b tgt=%h expected %b/%b/%h", lookup_pc,
                 pred_taken, pred_hit, pred_target, exp_taken(lookup_pc), exp_hit(lookup_pc),
                 exp_target(lookup_pc));
      end
      tick();
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    upd_pc     = 32'h0000_0014;
    upd_target = 32'h0000_0300;
    upd_taken  = 1'b1;
    upd_valid  = 1'b1;
    repeat (3) tick();
    upd_valid = 1'b0;
    lookup_pc = 32'h0000_0014;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_trained: got %b expected 1", pred_taken);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b0 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got r=%b t=%b expected 0/0", ready, pred_taken);
    end
    for (int k = 1; k <= ENTRIES; k++) begin
      tick();
      checks++;
      if (ready !== (k == ENTRIES)) begin
        errors++;
        $display("FAIL mid_reset_ready edge %0d: got %b expected %b", k, ready, k == ENTRIES);
      end
    end
    checks++;
    if (pred_taken !== 1'b0 || pred_taken !== exp_taken(lookup_pc) ||
        pred_hit !== exp_hit(lookup_pc)) begin
      errors++;
      $display("FAIL mid_reset_reinit: got t=%b h=%b expected 0/%b",
               pred_taken, pred_hit, exp_hit(lookup_pc));
    end
  endtask

  initial begin
    rst        = 1'b1;
    lookup_pc  = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    test_reset();
    test_saturation();
    test_alias();
`ifdef BRANCH_PREDICTOR_BTB_EN
    test_btb();
`endif
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch-direction predictor for the RV32I core, the counterpart to the branch comparator. The fetch stage looks up the current PC and gets a taken/not-taken guess, plus a target when the BTB option is compiled in. The branch comparator later produces the resolved outcome, which this block uses to train its 2-bit saturating counters. A self-clearing initialisation state machine walks the table after every reset.

## Interface
- `IDX_BITS`, default 6: table index width; `ENTRIES = 2**IDX_BITS`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `lookup_pc`  in  32: fetch PC to predict.
- `pred_taken`  out  1: predicted taken.
- `pred_hit`  out  1: BTB hit, meaning `pred_target` is valid.
- `pred_target`  out  32: predicted target; bits [1:0] always 0.
- `upd_valid`  in  1: resolved branch present this cycle.
- `upd_pc`  in  32: PC of the resolved branch.
- `upd_taken`  in  1: resolved outcome, i.e. the comparator's branch-true.
- `upd_target`  in  32: resolved target address.
- `ready`  out  1: table initialised; predictions and updates are live.

## Operation
- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[31:IDX_BITS+2]`.
- Each entry holds a 2-bit counter: 00 strongly not-taken (SN), 01 weakly not-taken (WN), 10 weakly taken (WT), 11 strongly taken (ST).
- Predict taken when the counter MSB is 1.
- FSM states are INIT and RUN.
  - `rst` forces INIT with `init_idx` = 0.
  - In INIT, each cycle writes entry `init_idx` with counter = WN and BTB valid = 0, then increments `init_idx`.
  - When `init_idx == ENTRIES-1` has been written, the next state is RUN.
  - RUN is terminal until the next `rst`.
- `ready` = (state == RUN).
- While `ready` = 0: `pred_taken`, `pred_hit` and `pred_target` are all 0, and `upd_valid` is ignored.
- Training, in RUN with `upd_valid` = 1:
  - Counter at the `upd_pc` index increments if `upd_taken`, else decrements.
  - The counter saturates at 11 and 00; there is no wrap.
- Lookup is combinational from `lookup_pc`.

## Timing
- Reset values: `ready` = 0, `pred_taken` = 0, `pred_hit` = 0, `pred_target` = 0.
- `ready` rises exactly `ENTRIES` clock edges after the first edge with `rst` low (64 for the default).
- Lookup latency: 0 cycles (same-cycle combinational read).
- Update latency: the write takes effect at the rising edge sampling `upd_valid`. It is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value. There is no bypass.
- Only one update per cycle. Back-to-back updates to the same index each apply in order.
- `rst` asserted mid-RUN: the next state is INIT, `init_idx` = 0, and all table contents are re-initialised.
- `rst` during INIT restarts the walk from 0.

## Configuration
- Macro: `BRANCH_PREDICTOR_BTB_EN`.
- Defined:
  - Adds a direct-mapped BTB per entry: valid bit, tag, and `target[31:2]`.
  - `pred_hit` = `ready` && valid && (tag match).
  - `pred_taken` = `pred_hit` && counter MSB.
  - `pred_target` = {stored target, 2'b00} when `pred_hit`, else 0.
  - On an update with `upd_taken` = 1, the block writes valid = 1, the tag of `upd_pc`, and `upd_target[31:2]`. A not-taken update leaves the BTB untouched.
- Undefined:
  - No BTB storage.
  - `pred_hit` = `ready`.
  - `pred_target` = 0.
  - `pred_taken` = `ready` && counter MSB.
  - `upd_target` is unused.

## Structure
- `bpred_pkg` holds:
  - the `ctr2_t` typedef (2-bit counter) with the SN/WN/WT/ST constants;
  - the `bpred_state_t` enum {INIT, RUN};
  - the `CTR_RESET = WN` constant.
- Sub-module `bpred_sat_ctr`: combinational next-counter from (current, `upd_taken`), saturating.
- The top level holds the FSM, the counter array, the optional BTB arrays, and the lookup/update muxing.

## Test plan
- Reset release: hold `rst` 3 cycles, then release. `ready` = 0 for 64 cycles and 1 on cycle 64. All outputs are 0 meanwhile. Updates issued during INIT have no effect.
- Saturation: with `lookup_pc` = 0x0000_0100, apply 3 taken updates. `pred_taken` goes 0→1 after the first update (WN→WT) and the counter holds at ST. Then apply 2 not-taken updates: `pred_taken` stays 1 after the first (ST→WT) and is 0 after the second (WT→WN).
- Aliasing and same-cycle read: PCs 0x0000_0004 and 0x0000_0104 share index 1. Train the first taken twice, and the second reads taken. Drive an update and a lookup to the same index in one cycle: the lookup shows the old value.
- BTB, with `BRANCH_PREDICTOR_BTB_EN` defined:
  - a taken update at `upd_pc` 0x0000_0020 with `upd_target` 0x0000_0400 makes a lookup of 0x0000_0020 return `pred_hit` = 1 and `pred_target` = 0x0000_0400;
  - a lookup of 0x0000_1020 (same index, different tag) returns `pred_hit` = 0 and `pred_taken` = 0.
- Mid-operation reset: train index 5 to ST, then pulse `rst` for 1 cycle. `ready` drops next cycle and rises 64 cycles later. Index 5 then predicts not-taken (WN).
